// File: rtl/rear_light_sequencer_pkg.sv
// Shared types and constants for the rear lamp sequencer.
package rear_light_pkg;
    localparam int DUTY_W    = 10;
    localparam int NUM_SIDES = 2;   // index 0 = left, 1 = right

    typedef logic [DUTY_W-1:0] duty_t;

    localparam duty_t DUTY_FULL_DEF = 10'd1023;
    localparam duty_t DUTY_TAIL_DEF = 10'd31;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLASH_ON  = 2'd1,
        FLASH_OFF = 2'd2,
        STEADY    = 2'd3
    } brakeState_t;
endpackage

// File: rtl/rear_light_sequencer_blink_timer.sv
// Turn/hazard blink timer: free-runs while requested, first half-period ON.
module blink_timer
    import rear_light_pkg::*;
#(
    parameter int HALF = 25_000_000
) (
    input  logic c50M,
    input  logic reset_n,
    input  logic run,
    output logic phase
);
    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt;
    logic          active;

    // 'active' distinguishes a fresh start from a mid-run wrap with phase 0
    always_ff @(posedge c50M) begin
        if (!reset_n || !run) begin
            cnt    <= '0;
            phase  <= 1'b0;
            active <= 1'b0;
        end else if (!active) begin
            cnt    <= '0;
            phase  <= 1'b1;
            active <= 1'b1;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/rear_light_sequencer.sv
// Rear lamp sequencer: samples requests, runs brake-flash FSM and blink timer,
// and selects the per-side duty word for the lamp PWM generators.
module rear_light_sequencer
    import rear_light_pkg::*;
#(
    parameter int    BLINK_HALF  = 25_000_000,
    parameter int    FLASH_HALF  = 3_125_000,
    parameter int    FLASH_COUNT = 3,
    parameter duty_t DUTY_FULL   = DUTY_FULL_DEF,
    parameter duty_t DUTY_TAIL   = DUTY_TAIL_DEF
) (
    input  logic              c50M,
    input  logic              reset_n,
    input  logic              brakeActive,
    input  logic              headLightActive,
    input  logic              turnLeft,
    input  logic              turnRight,
    input  logic              hazard,
    output logic [DUTY_W-1:0] leftDuty,
    output logic [DUTY_W-1:0] rightDuty,
    output logic              blinkPhase,
    output logic              flashing
);
    localparam int FCW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam int PCW = (FLASH_COUNT > 1) ? $clog2(FLASH_COUNT) : 1;
    localparam logic [FCW-1:0] FLAST = FCW'(FLASH_HALF - 1);

    logic sBrake, sHead, sHazard, sTurnL, sTurnR;

    always_ff @(posedge c50M) begin
        if (!reset_n) begin
            sBrake  <= 1'b0;
            sHead   <= 1'b0;
            sHazard <= 1'b0;
            sTurnL  <= 1'b0;
            sTurnR  <= 1'b0;
        end else begin
            sBrake  <= brakeActive;
            sHead   <= headLightActive;
            sHazard <= hazard;
            sTurnL  <= turnLeft;
            sTurnR  <= turnRight;
        end
    end

    // Both turns together fall out as hazard: each side sees its own request
    logic [NUM_SIDES-1:0] blinkReq;
    assign blinkReq = {sHazard | sTurnR, sHazard | sTurnL};

    blink_timer #(.HALF(BLINK_HALF)) uBlink (
        .c50M    (c50M),
        .reset_n (reset_n),
        .run     (|blinkReq),
        .phase   (blinkPhase)
    );

    brakeState_t          state;
    logic [FCW-1:0]       flashCnt;
    logic [PCW-1:0]       pairCnt;
    logic                 lit;
    logic                 tailOn;
    logic [NUM_SIDES-1:0] blinkSide;

    // IDLE with sampled brake high can only follow a rising edge (release
    // always returns to IDLE), so no separate edge detector is kept.
    always_ff @(posedge c50M) begin
        if (!reset_n) begin
            state     <= IDLE;
            flashCnt  <= '0;
            pairCnt   <= '0;
            lit       <= 1'b0;
            flashing  <= 1'b0;
            tailOn    <= 1'b0;
            blinkSide <= '0;
        end else begin
            tailOn    <= sHead;
            blinkSide <= blinkReq;
            if (!sBrake) begin
                state    <= IDLE;
                flashCnt <= '0;
                pairCnt  <= '0;
                lit      <= 1'b0;
                flashing <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= FLASH_ON;
                        flashCnt <= '0;
                        pairCnt  <= '0;
                        lit      <= 1'b1;
                        flashing <= 1'b1;
                    end
                    FLASH_ON: begin
                        if (flashCnt == FLAST) begin
                            state    <= FLASH_OFF;
                            flashCnt <= '0;
                            lit      <= 1'b0;
                        end else begin
                            flashCnt <= flashCnt + 1'b1;
                        end
                    end
                    FLASH_OFF: begin
                        if (flashCnt == FLAST) begin
                            flashCnt <= '0;
                            lit      <= 1'b1;
                            if (int'(pairCnt) + 1 < FLASH_COUNT) begin
                                state   <= FLASH_ON;
                                pairCnt <= pairCnt + 1'b1;
                            end else begin
                                state    <= STEADY;
                                flashing <= 1'b0;
                            end
                        end else begin
                            flashCnt <= flashCnt + 1'b1;
                        end
                    end
                    STEADY: begin
                        lit      <= 1'b1;
                        flashing <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        lit      <= 1'b0;
                        flashing <= 1'b0;
                    end
                endcase
            end
        end
    end

    duty_t                            level;
    logic [NUM_SIDES-1:0][DUTY_W-1:0] duty;

    assign level = lit ? DUTY_FULL : (tailOn ? DUTY_TAIL : '0);

    for (genvar i = 0; i < NUM_SIDES; i++) begin : gSide
        assign duty[i] = blinkSide[i] ? (blinkPhase ? DUTY_FULL : '0) : level;
    end

    assign leftDuty  = duty[0];
    assign rightDuty = duty[1];
endmodule

// File: tb/tb_rear_light_sequencer.sv
// Directed plus randomized bench; expectations come from elapsed-time rules.
module tb_rear_light_sequencer;
    localparam int BH = 4;
    localparam int FH = 2;
    localparam int FC = 2;

    logic       c50M = 1'b0;
    logic       reset_n = 1'b0;
    logic       brakeActive = 1'b0, headLightActive = 1'b0;
    logic       turnLeft = 1'b0, turnRight = 1'b0, hazard = 1'b0;
    logic [9:0] leftDuty, rightDuty;
    logic       blinkPhase, flashing;

    rear_light_sequencer #(
        .BLINK_HALF (BH),
        .FLASH_HALF (FH),
        .FLASH_COUNT(FC),
        .DUTY_FULL  (10'd1023),
        .DUTY_TAIL  (10'd31)
    ) dut (
        .c50M           (c50M),
        .reset_n        (reset_n),
        .brakeActive    (brakeActive),
        .headLightActive(headLightActive),
        .turnLeft       (turnLeft),
        .turnRight      (turnRight),
        .hazard         (hazard),
        .leftDuty       (leftDuty),
        .rightDuty      (rightDuty),
        .blinkPhase     (blinkPhase),
        .flashing       (flashing)
    );

    always #10 c50M = ~c50M;

    typedef struct packed {
        logic brake, head, haz, tl, tr;
    } in_t;

    int   total = 0, passed = 0;
    int   cyc = 0;
    int   blinkStart = 0, brakeStart = 0;
    in_t  prevEff = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
    endtask

    // One clock: predict outputs after this edge from the input history,
    // then absorb the inputs this edge samples.
    task automatic tick();
        int   eL, eR, eP, eF, t, lvl;
        logic bl, br, lit;
        in_t  cur;
        @(posedge c50M);
        cyc++;
        eL = 0; eR = 0; eP = 0; eF = 0;
        if (reset_n) begin
            bl  = prevEff.haz | prevEff.tl;
            br  = prevEff.haz | prevEff.tr;
            eP  = ((bl | br) && (((cyc - 1 - blinkStart) / BH) % 2 == 0)) ? 1 : 0;
            lit = 1'b0;
            if (prevEff.brake) begin
                t = cyc - 1 - brakeStart;
                if (t < 2 * FH * FC) begin
                    eF  = 1;
                    lit = ((t / FH) % 2 == 0);
                end else begin
                    lit = 1'b1;
                end
            end
            lvl = lit ? 1023 : (prevEff.head ? 31 : 0);
            eL  = bl ? (eP != 0 ? 1023 : 0) : lvl;
            eR  = br ? (eP != 0 ? 1023 : 0) : lvl;
        end
        cur = reset_n ? {brakeActive, headLightActive, hazard, turnLeft, turnRight} : '0;
        if ((cur.haz | cur.tl | cur.tr) && !(prevEff.haz | prevEff.tl | prevEff.tr))
            blinkStart = cyc;
        if (cur.brake && !prevEff.brake)
            brakeStart = cyc;
        prevEff = cur;
        #1;
        chk("leftDuty", 32'(leftDuty), 32'(eL));
        chk("rightDuty", 32'(rightDuty), 32'(eR));
        chk("blinkPhase", 32'(blinkPhase), 32'(eP));
        chk("flashing", 32'(flashing), 32'(eF));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // reset with every input high
        {brakeActive, headLightActive, turnLeft, turnRight, hazard} = 5'b11111;
        reset_n = 1'b0;
        ticks(3);
        {brakeActive, headLightActive, turnLeft, turnRight, hazard} = 5'b0;
        reset_n = 1'b1;
        ticks(2);

        // brake flash with headlights on
        headLightActive = 1'b1;
        ticks(3);
        brakeActive = 1'b1;
        ticks(14);

        // release during the second FLASH_ON, then re-press
        brakeActive = 1'b0;
        ticks(3);
        brakeActive = 1'b1;
        ticks(5);
        brakeActive = 1'b0;
        ticks(3);
        brakeActive = 1'b1;
        ticks(12);

        // left turn over steady brake
        turnLeft = 1'b1;
        ticks(20);
        turnLeft = 1'b0;
        ticks(3);

        // both turns without hazard
        brakeActive = 1'b0;
        turnLeft    = 1'b1;
        turnRight   = 1'b1;
        ticks(12);
        turnLeft  = 1'b0;
        turnRight = 1'b0;
        ticks(3);

        // right turn switched to hazard mid-blink
        turnRight = 1'b1;
        ticks(6);
        hazard    = 1'b1;
        turnRight = 1'b0;
        ticks(10);
        hazard = 1'b0;
        ticks(2);

        // brake held through reset release, then reset mid-sequence
        brakeActive = 1'b1;
        reset_n     = 1'b0;
        tick();
        reset_n = 1'b1;
        ticks(5);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        ticks(12);

        // brake edge during hazard: flashing visible, lamps only blink
        brakeActive = 1'b0;
        hazard      = 1'b1;
        ticks(3);
        brakeActive = 1'b1;
        ticks(12);
        hazard      = 1'b0;
        brakeActive = 1'b0;
        ticks(2);

        // randomized: sparse input toggles with occasional reset pulses
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 4))
                    0: brakeActive     = ~brakeActive;
                    1: headLightActive = ~headLightActive;
                    2: turnLeft        = ~turnLeft;
                    3: turnRight       = ~turnRight;
                    default: hazard    = ~hazard;
                endcase
            end
            reset_n = ($urandom_range(0, 99) != 0);
            tick();
        end
        reset_n = 1'b1;
        ticks(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rear_light_sequencer.md
# rear_light_sequencer

Sequences the two rear lamp PWM channels (left, right) for brake, tail, turn and hazard functions. Arbitrates these requests per side and produces a registered 10-bit duty word for each side, which drives a `PWMGenerator` instance per lamp. Also owns the blink timer and the emergency brake-flash sequence. The block sits between the vehicle-input decode logic and the lamp PWM generators.

## Interface

**Parameters**

- `BLINK_HALF`, default 25_000_000: cycles per turn/hazard blink half-period (0.5 s at 50 MHz).
- `FLASH_HALF`, default 3_125_000: cycles per brake-flash half-period (62.5 ms).
- `FLASH_COUNT`, default 3: number of ON/OFF flash pairs before steady brake.
- `DUTY_FULL`, default 10'd1023: brake and turn-ON duty.
- `DUTY_TAIL`, default 10'd31: tail-lamp duty when headlights are on.

**Ports**

- `c50M` input 1: system clock, 50 MHz.
- `reset_n` input 1: reset, synchronous, active-low.
- `brakeActive` input 1: brake pedal pressed.
- `headLightActive` input 1: headlights on; enables the tail level.
- `turnLeft` input 1: left turn request.
- `turnRight` input 1: right turn request.
- `hazard` input 1: hazard request.
- `leftDuty` output 10: left lamp duty.
- `rightDuty` output 10: right lamp duty.
- `blinkPhase` output 1: 1 during the blink ON half-period (drives the dash indicator).
- `flashing` output 1: 1 while the brake-flash sequence is in FLASH_ON or FLASH_OFF.

## Operation

- **Input sampling:** all request inputs are registered once (sampling stage) before use.
- **Blink request:** `blinkL = hazard | turnLeft`, `blinkR = hazard | turnRight`. `turnLeft & turnRight` is treated as hazard.
- **Blink timer behaviour:**
  - It runs only while `blinkL | blinkR`.
  - When the first request is asserted from none, the counter clears and the phase starts ON, so the first blink is immediate.
  - The phase toggles when the counter reaches `BLINK_HALF-1`, then the counter wraps to 0.
  - When there are no requests, the counter is 0 and `blinkPhase` is 0.
  - Changing the request set while any request remains (e.g. left to hazard) does not restart the timer.
- **Brake FSM states:** IDLE, FLASH_ON, FLASH_OFF, STEADY.
  - IDLE to FLASH_ON on the sampled brake rising edge; the flash counter clears.
  - FLASH_ON to FLASH_OFF after `FLASH_HALF` cycles.
  - FLASH_OFF to FLASH_ON after `FLASH_HALF` cycles while fewer than `FLASH_COUNT` pairs are complete; otherwise to STEADY.
  - Any state to IDLE when the sampled brake is 0. This has priority over all other transitions.
  - A brake re-press restarts the flash sequence from FLASH_ON.
- **Non-blink side level:** `DUTY_FULL` in FLASH_ON or STEADY. In IDLE or FLASH_OFF: `DUTY_TAIL` if headlights are on, else 0.
- **Blinking side level:** `DUTY_FULL` when `blinkPhase`=1, else 0. Blinking overrides brake and tail on that side. During hazard, both sides blink and brake is not visible.
- **Width:** all duty values are 10-bit unsigned. Counters are sized by `$clog2` of their parameter; no overflow is possible.

## Timing

- **Reset values:** when `reset_n`=0 at a clock edge, the next-cycle outputs are `leftDuty`=0, `rightDuty`=0, `blinkPhase`=0 and `flashing`=0. The FSM goes to IDLE and all counters and sampling registers are 0.
- **Latency:** an input change appears on the duty outputs 2 cycles later (sampling stage, then output register).
- **Output registration:** `blinkPhase` and `flashing` are registered and change in the same cycle as the duty outputs.
- **Brake already held at reset release:** it is sampled as a rising edge, so the flash sequence runs.
- **Reset mid-sequence:** this is a full restart; no state is retained.
- **Brake edge during hazard:** the FSM still sequences the brake flash internally. `flashing` asserts, but the lamps show only the blink.

## Structure

- **Package `rear_light_pkg`:**
  - Brake FSM state enum.
  - Duty width constant (10).
  - Default duty constants.
- **Sub-module `blink_timer`:**
  - Inputs: `c50M`, `reset_n`, `run`.
  - Output: `phase`.
  - Parameter: `HALF`.
- **Top level:** sampling stage, brake FSM with flash counter, per-side output mux.

## Test plan

All scenarios use `BLINK_HALF`=4, `FLASH_HALF`=2, `FLASH_COUNT`=2.

1. **Reset:** assert `reset_n`=0 with all inputs high, then hold `reset_n`=0 for 3 cycles. Required: both duties 0, `blinkPhase`=0, `flashing`=0.
2. **Brake flash:** headlights on; raise brake and hold it. Required duty sequence on both sides: 1023×2, 31×2, 1023×2, 31×2, then steady 1023. `flashing` is 1 for exactly 8 cycles.
3. **Brake release mid-flash:** release brake in the second FLASH_ON. Required: duty is 31 two cycles later and the FSM is in IDLE. A re-press gives a fresh 1023×2 pattern.
4. **Left turn with brake held in STEADY:**
   - Left duty: 1023×4, 0×4, repeating, with the first ON starting 2 cycles after the request.
   - Right duty: steady 1023.
5. **Both turns, no hazard:** assert `turnLeft` and `turnRight` with `hazard`=0. Required: both sides blink in phase, identical to hazard.
6. **Switch turn to hazard mid-blink:** switch from `turnRight` to `hazard` mid-blink. Required: the blink phase is not restarted, and left joins right in phase.
